// File: rtl/seg_scan.sv
// Four-digit common-anode seven-segment scanner; latches value/blank/dp on load and swaps them in at frame boundaries.
// Outputs registered from next-state, so they track cnt/idx/active in the same cycle; load is always accepted, no backpressure.
module seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {GAP, SHOW} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] pend_val, act_val, act_val_nxt;
  logic [3:0]  pend_blank, act_blank, act_blank_nxt;
  logic [3:0]  pend_dp, act_dp, act_dp_nxt;
  logic        slot_end, frame_nxt;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;
  logic [3:0]  an_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    slot_end      = (cnt == CW'(REFRESH_DIV - 1));
    cnt_nxt       = slot_end ? '0 : cnt + CW'(1);
    idx_nxt       = slot_end ? idx + 2'd1 : idx;
    frame_nxt     = slot_end && (idx == 2'd3);
    // Active takes the pre-edge pending contents; a coincident load lands next frame.
    act_val_nxt   = frame_nxt ? pend_val   : act_val;
    act_blank_nxt = frame_nxt ? pend_blank : act_blank;
    act_dp_nxt    = frame_nxt ? pend_dp    : act_dp;

    state_nxt = state;
    case (state)
      GAP:     if (cnt_nxt == CW'(BLANK_CYCLES)) state_nxt = SHOW;
      default: if (slot_end) state_nxt = GAP;
    endcase

    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    if (state_nxt == SHOW && !act_blank_nxt[idx_nxt]) begin
      an_nxt  = ~(4'b0001 << idx_nxt);
      seg_nxt = hex7(act_val_nxt[{idx_nxt, 2'b00} +: 4]);
      dp_nxt  = ~act_dp_nxt[idx_nxt];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= GAP;
      cnt        <= '0;
      idx        <= 2'd0;
      pend_val   <= 16'h0000;
      pend_blank <= 4'b1111;
      pend_dp    <= 4'b0000;
      act_val    <= 16'h0000;
      act_blank  <= 4'b1111;
      act_dp     <= 4'b0000;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      act_val    <= act_val_nxt;
      act_blank  <= act_blank_nxt;
      act_dp     <= act_dp_nxt;
      if (load) begin
        pend_val   <= value;
        pend_blank <= blank;
        pend_dp    <= dp_in;
      end
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_tick <= frame_nxt;
    end
  end

endmodule
